// File: rtl/ex_div_unit_pkg.sv
// Shared constants for the execute-stage divider: op codes (shared with the ALU decoder),
// FSM state encoding and datapath width.
package ex_div_unit_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    localparam logic [4:0] OP_DIV  = 5'b10100;
    localparam logic [4:0] OP_DIVU = 5'b10101;
    localparam logic [4:0] OP_REM  = 5'b10110;
    localparam logic [4:0] OP_REMU = 5'b10111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // The four divide codes are exactly the 101xx block of ALUControl.
    function automatic logic isDivOp(input logic [4:0] op);
        return (op[4:2] == 3'b101);
    endfunction

endpackage

// File: rtl/ex_div_unit_div_step.sv
// One radix-2 restoring division step: shift {rem,quo} left, trial-subtract the divisor
// from the upper half and keep the difference when it does not borrow.
module div_step
    import ex_div_unit_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;
    logic           w_borrow;

    // The shifted remainder can need WIDTH+1 bits, and since it is always below twice the
    // divisor the top bit of the WIDTH+1-bit difference is exactly the borrow.
    assign w_shifted = {i_rem, i_quo[WIDTH-1]};
    assign w_diff    = w_shifted - {1'b0, i_divisor};
    assign w_borrow  = w_diff[WIDTH];

    assign o_rem = w_borrow ? w_shifted[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign o_quo = {i_quo[WIDTH-2:0], ~w_borrow};

endmodule

// File: rtl/ex_div_unit.sv
// Iterative restoring divider beside the ALU: DIV/DIVU/REM/REMU with RISC-V M special cases,
// stalling the pipeline through busy while it iterates.
module ex_div_unit #(
    parameter int XLEN  = ex_div_unit_pkg::XLEN,
    parameter int CNT_W = ex_div_unit_pkg::CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] rdA,
    input  logic [XLEN-1:0] rdB,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    import ex_div_unit_pkg::*;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_divisor;
    logic            r_isRem;
    logic            r_negQ;
    logic            r_negR;
    logic            r_done;
    logic [XLEN-1:0] r_result;

    logic            w_isSigned;
    logic            w_signA;
    logic            w_signB;
    logic [XLEN-1:0] w_absA;
    logic [XLEN-1:0] w_absB;
    logic            w_divZero;
    logic            w_overflow;
    logic            w_special;
    logic            w_accept;
    logic [XLEN-1:0] w_specialResult;
    logic [XLEN-1:0] w_remNext;
    logic [XLEN-1:0] w_quoNext;
    logic [XLEN-1:0] w_quoFinal;
    logic [XLEN-1:0] w_remFinal;
    logic [XLEN-1:0] w_final;

    // Signed ops have op[0]=0; magnitudes are unsigned, so |MIN_NEG| stays MIN_NEG.
    assign w_isSigned = ~op[0];
    assign w_signA    = w_isSigned & rdA[XLEN-1];
    assign w_signB    = w_isSigned & rdB[XLEN-1];
    assign w_absA     = w_signA ? -rdA : rdA;
    assign w_absB     = w_signB ? -rdB : rdB;

    assign w_divZero  = (rdB == '0);
    assign w_overflow = w_isSigned & (rdA == MIN_NEG) & (rdB == '1);
    assign w_special  = w_divZero | w_overflow;
    assign w_accept   = (r_state == IDLE) & start & isDivOp(op) & ~flush;

    always_comb begin
        w_specialResult = '0;
        if (w_divZero) begin
            w_specialResult = op[1] ? rdA : '1;
        end else begin
            w_specialResult = op[1] ? '0 : MIN_NEG;
        end
    end

    div_step #(
        .WIDTH(XLEN)
    ) u_step (
        .i_rem    (r_rem),
        .i_quo    (r_quo),
        .i_divisor(r_divisor),
        .o_rem    (w_remNext),
        .o_quo    (w_quoNext)
    );

    assign w_quoFinal = r_negQ ? -w_quoNext : w_quoNext;
    assign w_remFinal = r_negR ? -w_remNext : w_remNext;
    assign w_final    = r_isRem ? w_remFinal : w_quoFinal;

    assign busy   = (w_accept & ~w_special) | (r_state == CALC);
    assign done   = r_done;
    assign result = r_result;

    // Special cases skip iteration and publish their result straight from the accept edge;
    // the last CALC step publishes the sign-corrected result on its way to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_isRem   <= 1'b0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
        end else if (flush) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_isRem   <= op[1];
                        r_negQ    <= w_signA ^ w_signB;
                        r_negR    <= w_signA;
                        r_rem     <= '0;
                        r_quo     <= w_absA;
                        r_divisor <= w_absB;
                        r_cnt     <= CNT_W'(XLEN - 1);
                        if (w_special) begin
                            r_result <= w_specialResult;
                            r_done   <= 1'b1;
                            r_state  <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_rem <= w_remNext;
                    r_quo <= w_quoNext;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == '0) begin
                        r_result <= w_final;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed-vector bench for ex_div_unit: latency, busy/done handshake, sign fix-up,
// special cases, flush/reset abort and ignored starts.
module tb_ex_div_unit;
    import ex_div_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  op;
    logic [31:0] rdA;
    logic [31:0] rdB;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int vectorCount;
    int miscompareCount;

    ex_div_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .rdA   (rdA),
        .rdB   (rdB),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompareCount++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Presents a request at the start of a cycle; the request cycle is cycle 0.
    task automatic applyStimulus(input logic [4:0] opIn, input logic [31:0] a,
                                 input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = opIn;
        rdA   = a;
        rdB   = b;
    endtask

    task automatic runDivide(input string tag, input logic [4:0] opIn, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] expResult,
                             input int expDoneCycle, input int expBusyCycles, input bit poke);
        int cyc;
        int busyCyc;
        applyStimulus(opIn, a, b);
        #1;
        checkOutput({tag, ".doneLowAtStart"}, 32'(done), 32'd0);
        cyc     = 0;
        busyCyc = 0;
        while (!done && cyc < 100) begin
            if (busy) busyCyc++;
            @(negedge clk);
            cyc++;
            start = poke && (cyc < 30) && (cyc % 4 == 3);
            #1;
        end
        start = 1'b0;
        checkOutput({tag, ".doneCycle"}, 32'(cyc), 32'(expDoneCycle));
        checkOutput({tag, ".busyCycles"}, 32'(busyCyc), 32'(expBusyCycles));
        checkOutput({tag, ".busyInDone"}, 32'(busy), 32'd0);
        checkOutput({tag, ".result"}, result, expResult);
    endtask

    task automatic runInterrupted(input string tag, input bit useReset, input int atCycle,
                                  input logic [31:0] expHeld);
        int doneCount;
        int busyCount;
        applyStimulus(OP_DIV, 32'd1000, 32'd7);
        for (int c = 1; c <= atCycle; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        checkOutput({tag, ".busyBeforeAbort"}, 32'(busy), 32'd1);
        if (useReset) rst = 1'b1;
        else flush = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        flush = 1'b0;
        #1;
        checkOutput({tag, ".busyAfter"}, 32'(busy), 32'd0);
        checkOutput({tag, ".doneAfter"}, 32'(done), 32'd0);
        checkOutput({tag, ".resultAfter"}, result, expHeld);
        doneCount = 0;
        busyCount = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (done) doneCount++;
            if (busy) busyCount++;
        end
        checkOutput({tag, ".noDonePulse"}, 32'(doneCount), 32'd0);
        checkOutput({tag, ".staysIdle"}, 32'(busyCount), 32'd0);
    endtask

    initial begin
        int doneCount;
        vectorCount     = 0;
        miscompareCount = 0;
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 5'd0;
        rdA   = 32'd0;
        rdB   = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.done", 32'(done), 32'd0);
        checkOutput("reset.result", result, 32'd0);

        runDivide("div_m7_2",   OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 33, 1'b0);
        runDivide("rem_m7_2",   OP_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 33, 1'b0);
        runDivide("remu_fff9",  OP_REMU, 32'hFFFFFFF9, 32'd2, 32'h00000001, 33, 33, 1'b0);
        runDivide("divu_fff9",  OP_DIVU, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 33, 33, 1'b0);
        runDivide("rem_m6_m4",  OP_REM,  32'hFFFFFFFA, 32'hFFFFFFFC, 32'hFFFFFFFE, 33, 33, 1'b0);
        runDivide("divu_by0",   OP_DIVU, 32'd100, 32'd0, 32'hFFFFFFFF, 1, 0, 1'b0);
        runDivide("rem_by0",    OP_REM,  32'd100, 32'd0, 32'd100, 1, 0, 1'b0);

        runInterrupted("flush", 1'b0, 10, 32'd100);
        runDivide("divu_1000_7", OP_DIVU, 32'd1000, 32'd7, 32'd142, 33, 33, 1'b0);
        runInterrupted("reset", 1'b1, 20, 32'd0);
        runDivide("pokeDuringCalc", OP_DIVU, 32'd1000, 32'd7, 32'd142, 33, 33, 1'b1);

        // A non-divide op must be ignored entirely.
        applyStimulus(5'b00000, 32'd5, 32'd3);
        #1;
        checkOutput("add.busy", 32'(busy), 32'd0);
        doneCount = 0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (done) doneCount++;
            @(negedge clk);
        end
        checkOutput("add.noDone", 32'(doneCount), 32'd0);
        checkOutput("add.resultHeld", result, 32'd142);

        // Back-to-back: each request starts in the cycle right after the previous done.
        runDivide("div_ovf",    OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0, 1'b0);
        runDivide("rem_ovf",    OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 0, 1'b0);
        runDivide("divu_noOvf", OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33, 33, 1'b0);
        runDivide("div_zero_5", OP_DIV,  32'd0, 32'd5, 32'd0, 33, 33, 1'b0);
        runDivide("rem_m7_by0", OP_REM,  32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1, 0, 1'b0);
        runDivide("div_m7_by0", OP_DIV,  32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 1, 0, 1'b0);
        runDivide("div_1000_7", OP_DIV,  32'd1000, 32'd7, 32'd142, 33, 33, 1'b0);
        runDivide("div_m1000_7", OP_DIV, 32'hFFFFFC18, 32'd7, 32'hFFFFFF72, 33, 33, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Iterative radix-2 restoring divider in the execute stage, beside the combinational ALU.
- Takes the same rdA/rdB operands and the 5-bit ALUControl code. It computes DIV/DIVU/REM/REMU over multiple cycles, replacing the single-cycle divide path.
- Raises a stall to the hazard unit while it computes.
- Its result is muxed with ALUresult into the EX/MEM register in the cycle done is high.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 5, iteration counter width; must equal log2(XLEN).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a divide this cycle; sampled only in IDLE.
- op  input  5  ALUControl code: 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
- rdA  input  XLEN  dividend.
- rdB  input  XLEN  divisor.
- flush  input  1  kill any in-flight operation (branch mispredict/trap).
- busy  output  1  stall request to the pipeline (combinational).
- done  output  1  one-cycle pulse; result valid this cycle.
- result  output  XLEN  quotient or remainder, held until the next accepted start.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; done=0; result=0; counter=0; internal registers=0.
  - rst has priority over flush and start.
- Accepting a request:
  - A request is accepted when state=IDLE, start=1 and op is one of the four divide codes.
  - Any other op with start=1 is ignored, and busy stays low.
  - start outside IDLE is ignored; the hazard unit holds start and operands stable while busy.
- Operand capture on accept:
  - Store op and the sign flags: signed op and operand[XLEN-1].
  - Store |rdA| and |rdB| for signed ops, raw values for unsigned ops.
  - Clear the partial remainder.
  - Load counter=XLEN-1.
- FSM, states IDLE, CALC, DONE:
  - IDLE -> CALC on an accepted normal request.
  - IDLE -> DONE on an accepted special case (fast path, no iteration).
  - CALC performs one restoring step per cycle.
    - Shift {rem,quo} left by 1.
    - Trial-subtract the divisor from the upper half.
    - If the difference is non-negative, keep it and set quo[0]=1.
  - CALC: counter decrements each step; after the step with counter==0, go to DONE.
  - The final result is registered on the CALC->DONE edge.
  - DONE -> IDLE unconditionally after one cycle.
- busy is asserted when (state==IDLE & accepted request & not special case) or state==CALC. It is low in DONE, so the pipeline advances and EX/MEM captures result.
- Latency:
  - Normal request: done high XLEN+1 cycles after the accept edge (33 for XLEN=32).
  - Special case: done high the cycle after accept; busy is never asserted.
- Sign fix-up, applied when registering the result:
  - Quotient is negated iff the op is signed and sign(rdA) != sign(rdB).
  - Remainder is negated iff the op is signed and sign(rdA)=1.
  - DIV/DIVU select the quotient; REM/REMU select the remainder.
- Special cases (RISC-V M semantics):
  - Divisor 0: quotient=all ones (both signed and unsigned); remainder=rdA.
  - Signed overflow (rdA=0x80000000, rdB=0xFFFFFFFF, op DIV/REM): quotient=0x80000000, remainder=0.
  - Dividend 0 with nonzero divisor takes the normal path and yields 0.
- flush=1 at an edge:
  - From any state, go to IDLE; done stays 0 next cycle; result is unchanged.
  - A start in the same cycle as flush is dropped.
- Arithmetic: the trial subtract is XLEN+1 bits wide so the borrow is explicit. All magnitudes are unsigned XLEN-bit values; |0x80000000| = 0x80000000 as unsigned.

Decomposition:
- Shared package:
  - Divide op-code constants (OP_DIV=5'b10100, OP_DIVU, OP_REM, OP_REMU), shared with the ALU decoder.
  - FSM state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2).
  - XLEN.
- One combinational sub-module, div_step: inputs {rem, quo, divisor}; outputs the next {rem, quo}.
- The FSM, capture registers and sign fix-up stay in ex_div_unit.

Test Plan:
- DIV rdA=-7 (0xFFFFFFF9), rdB=2 -> busy high 33 cycles, done at cycle 33, result=0xFFFFFFFD (-3).
- REM -7,2 -> 0xFFFFFFFF (-1).
- REMU 0xFFFFFFF9,2 -> 0x00000001.
- DIVU 0xFFFFFFF9,2 -> 0x7FFFFFFC.
- DIVU 100,0 -> done next cycle, busy never high, result=0xFFFFFFFF.
- REM 100,0 -> result=100.
- DIV 0x80000000,0xFFFFFFFF -> done next cycle, result=0x80000000.
- REM 0x80000000,0xFFFFFFFF -> result=0.
- DIV 1000,7 with flush at cycle 10 -> state IDLE, busy low next cycle, no done pulse, result holds its prior value.
- After that flush, a new DIVU 1000,7 -> result=142.
- DIV 1000,7 with rst at cycle 20 -> done=0, result=0, busy=0.
- start pulses during CALC are ignored, and the original result 142 appears at cycle 33.
- start with op=00000 (ADD) -> busy=0, no done; back-to-back DIVs (a start in the cycle after done) -> both results correct.
